// File: rtl/stream_req_gen_pkg.sv
// Shared defaults for the streaming cache-line request generator.
// Widths here are the defaults; modules may override them through parameters.
package stream_req_gen_pkg;

  localparam int def_addr_width = 64;
  localparam int def_nstrms     = 64;
  localparam int def_cl_bytes   = 128;
  localparam int def_ncl_width  = 16;
  localparam int line_off_width = $clog2(def_cl_bytes);

endpackage

// File: rtl/stream_req_gen_if.sv
// Configuration, request and completion signals of stream_req_gen.
// slave is the generator side, master is whoever configures and consumes requests.
interface stream_req_gen_if
  import stream_req_gen_pkg::*;
#(
  parameter int addr_width = def_addr_width,
  parameter int nstrms     = def_nstrms,
  parameter int ncl_width  = def_ncl_width
);

  localparam int nstrms_width = $clog2(nstrms);

  logic                    i_cfg_v;
  logic                    i_cfg_r;
  logic [nstrms_width-1:0] i_cfg_sid;
  logic [addr_width-1:0]   i_cfg_ea;
  logic [ncl_width-1:0]    i_cfg_ncl;

  logic                    o_req_v;
  logic                    o_req_r;
  logic [nstrms_width-1:0] o_req_sid;
  logic [addr_width-1:0]   o_req_ea;

  logic                    o_done_v;
  logic [nstrms_width-1:0] o_done_sid;
  logic                    o_busy;

  modport master (
    output i_cfg_v, i_cfg_sid, i_cfg_ea, i_cfg_ncl, o_req_r,
    input  i_cfg_r, o_req_v, o_req_sid, o_req_ea, o_done_v, o_done_sid, o_busy
  );

  modport slave (
    input  i_cfg_v, i_cfg_sid, i_cfg_ea, i_cfg_ncl, o_req_r,
    output i_cfg_r, o_req_v, o_req_sid, o_req_ea, o_done_v, o_done_sid, o_busy
  );

endinterface

// File: rtl/base_rr_arb.sv
// Round-robin arbiter: searches from the slot after the last grant, returns
// a one-hot grant plus its encoded index; the pointer only moves when en is high.
module base_rr_arb #(
  parameter int n     = 64,
  parameter int sid_w = $clog2(n)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [n-1:0]     req,
  input  logic             en,
  output logic [n-1:0]     grant,
  output logic [sid_w-1:0] grant_sid,
  output logic             grant_v
);

  logic [sid_w-1:0] ptr_reg;
  logic [sid_w-1:0] ptr_next;
  logic [sid_w-1:0] sel;
  logic             found;
  logic [31:0]      idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < n; i++) begin
      idx = (32'(ptr_reg) + 32'(i)) % 32'(n);
      if (!found && req[idx[sid_w-1:0]]) begin
        found = 1'b1;
        sel   = idx[sid_w-1:0];
      end
    end
  end

  assign ptr_next  = (sel == sid_w'(n - 1)) ? '0 : sel + 1'b1;
  assign grant_sid = sel;
  assign grant_v   = found;

  for (genvar gi = 0; gi < n; gi++) begin : g_gnt
    assign grant[gi] = found && (sel == sid_w'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (en && found) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/stream_req_gen.sv
// Per-stream cache-line request generator: each configured stream emits ncl
// line-aligned addresses, streams are interleaved round-robin into one request port.
module stream_req_gen
  import stream_req_gen_pkg::*;
#(
  parameter int addr_width = def_addr_width,
  parameter int nstrms     = def_nstrms,
  parameter int cl_bytes   = def_cl_bytes,
  parameter int ncl_width  = def_ncl_width
) (
  input  logic            clk,
  input  logic            reset,
  stream_req_gen_if.slave bus
);

  localparam int nstrms_width = $clog2(nstrms);
  localparam int off_w = (cl_bytes == def_cl_bytes) ? line_off_width : $clog2(cl_bytes);
  localparam logic [addr_width-1:0] line_mask =
      ~((addr_width'(1) << off_w) - addr_width'(1));

  logic [nstrms-1:0]       active;
  logic [addr_width-1:0]   next_ea   [nstrms];
  logic [ncl_width-1:0]    remaining [nstrms];
  logic [nstrms-1:0]       eligible;

  logic [nstrms-1:0]       grant_onehot;
  logic [nstrms_width-1:0] grant_sid;
  logic                    grant_v;

  logic                    out_v_reg;
  logic [nstrms_width-1:0] out_sid_reg;
  logic [addr_width-1:0]   out_ea_reg;
  logic                    out_last_reg;
  logic                    done_v_reg;
  logic [nstrms_width-1:0] done_sid_reg;

  logic cfg_ready;
  logic cfg_fire;
  logic cfg_start;
  logic out_fire;
  logic out_load;
  logic retire;

  // A stream cannot be reconfigured until its last request has been accepted.
  assign cfg_ready = !active[bus.i_cfg_sid];
  assign cfg_fire  = bus.i_cfg_v && cfg_ready;
  assign cfg_start = cfg_fire && (bus.i_cfg_ncl != '0);

  assign out_fire = out_v_reg && bus.o_req_r;
  assign out_load = grant_v && (!out_v_reg || out_fire);
  assign retire   = out_fire && out_last_reg;

  for (genvar gi = 0; gi < nstrms; gi++) begin : g_strm
    logic                  active_reg;
    logic [addr_width-1:0] next_ea_reg;
    logic [ncl_width-1:0]  remaining_reg;
    logic                  cfg_hit;
    logic                  load_hit;
    logic                  retire_hit;

    assign cfg_hit    = cfg_start && (bus.i_cfg_sid == nstrms_width'(gi));
    assign load_hit   = out_load && grant_onehot[gi];
    assign retire_hit = retire && (out_sid_reg == nstrms_width'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        active_reg <= 1'b0;
      end else if (cfg_hit) begin
        active_reg <= 1'b1;
      end else if (retire_hit) begin
        active_reg <= 1'b0;
      end
    end

    // Address and count are only meaningful while active, so they need no reset.
    always_ff @(posedge clk) begin
      if (cfg_hit) begin
        next_ea_reg   <= bus.i_cfg_ea & line_mask;
        remaining_reg <= bus.i_cfg_ncl;
      end else if (load_hit) begin
        next_ea_reg   <= next_ea_reg + addr_width'(cl_bytes);
        remaining_reg <= remaining_reg - ncl_width'(1);
      end
    end

    assign active[gi]    = active_reg;
    assign next_ea[gi]   = next_ea_reg;
    assign remaining[gi] = remaining_reg;
    assign eligible[gi]  = active_reg && (remaining_reg != '0);
  end

  base_rr_arb #(
    .n     (nstrms),
    .sid_w (nstrms_width)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .en        (out_load),
    .grant     (grant_onehot),
    .grant_sid (grant_sid),
    .grant_v   (grant_v)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v_reg    <= 1'b0;
      out_sid_reg  <= '0;
      out_ea_reg   <= '0;
      out_last_reg <= 1'b0;
      done_v_reg   <= 1'b0;
      done_sid_reg <= '0;
    end else begin
      done_v_reg <= retire;
      if (retire) begin
        done_sid_reg <= out_sid_reg;
      end
      if (out_load) begin
        out_v_reg    <= 1'b1;
        out_sid_reg  <= grant_sid;
        out_ea_reg   <= next_ea[grant_sid];
        out_last_reg <= (remaining[grant_sid] == ncl_width'(1));
      end else if (out_fire) begin
        out_v_reg <= 1'b0;
      end
    end
  end

  assign bus.i_cfg_r    = cfg_ready;
  assign bus.o_req_v    = out_v_reg;
  assign bus.o_req_sid  = out_sid_reg;
  assign bus.o_req_ea   = out_ea_reg;
  assign bus.o_done_v   = done_v_reg;
  assign bus.o_done_sid = done_sid_reg;
  assign bus.o_busy     = (|active) || out_v_reg;

endmodule
